// File: rtl/pipe_pooling_buf_pkg.sv
// Shared types for the HWCE-to-pooling elastic buffer: FSM state encoding and per-word tags.
package hwce_types;

   typedef enum logic [1:0] {
      PB_IDLE  = 2'd0,
      PB_RUN   = 2'd1,
      PB_DRAIN = 2'd2
   } pipe_pool_buf_state_t;

   // Position markers stored alongside each buffered word
   typedef struct packed {
      logic eol;
      logic last;
   } pb_tags_t;

endpackage

// File: rtl/pipe_pooling_buf_if.sv
// Stream bundle between the engine output, the buffer and the pooling layer.
interface pipe_pooling_buf_if #(
   parameter int AXI_WIDTH = 32,
   parameter int NPX       = 4
);
   localparam int DW = NPX * AXI_WIDTH;
   localparam int KW = DW / 8;

   logic          y_in_TVALID_i;
   logic          y_in_TREADY_o;
   logic [DW-1:0] y_in_TDATA_i;
   logic [KW-1:0] y_in_TKEEP_i;

   logic          pool_TVALID_o;
   logic          pool_TREADY_i;
   logic [DW-1:0] pool_TDATA_o;
   logic [KW-1:0] pool_TKEEP_o;
   logic [KW-1:0] pool_TSTRB_o;
   logic          pool_EOL_o;
   logic          pool_TLAST_o;

   // slave: the buffer itself; master: engine plus pooling layer around it
   modport slave (
      input  y_in_TVALID_i, y_in_TDATA_i, y_in_TKEEP_i, pool_TREADY_i,
      output y_in_TREADY_o, pool_TVALID_o, pool_TDATA_o, pool_TKEEP_o,
             pool_TSTRB_o, pool_EOL_o, pool_TLAST_o
   );

   modport master (
      output y_in_TVALID_i, y_in_TDATA_i, y_in_TKEEP_i, pool_TREADY_i,
      input  y_in_TREADY_o, pool_TVALID_o, pool_TDATA_o, pool_TKEEP_o,
             pool_TSTRB_o, pool_EOL_o, pool_TLAST_o
   );
endinterface

// File: rtl/pipe_pooling_buf_fifo.sv
// Generic synchronous FIFO with occupancy count and synchronous flush.
module pool_stream_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == LW'(DEPTH));
   assign empty   = (count == '0);
   assign level   = count;
   assign rdata   = mem[rd_ptr];
   // A full FIFO refuses pushes even when a pop frees a slot in the same cycle
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pipe_pooling_buf.sv
// Elastic stage between HWCE output and pooling: buffers words and tags row/feature ends.
//
//   state    | meaning
//   PB_IDLE  | waiting for start, input closed
//   PB_RUN   | accepting words, tracking col/row/feat
//   PB_DRAIN | all words accepted, waiting for FIFO to empty
module pipe_pooling_buf
   import hwce_types::*;
#(
   parameter int AXI_WIDTH = 32,
   parameter int NPX       = 4,
   parameter int DEPTH     = 4,
   parameter int CNT_W     = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   start_i,
   input  logic [CNT_W-1:0]       row_width_i,
   input  logic [CNT_W-1:0]       n_rows_i,
   input  logic [CNT_W-1:0]       n_feat_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   output logic [$clog2(DEPTH):0] level_o,
   pipe_pooling_buf_if.slave      bus
);
   localparam int DW = NPX * AXI_WIDTH;
   localparam int KW = DW / 8;
   localparam int LW = $clog2(DEPTH) + 1;
   localparam int EW = DW + KW + $bits(pb_tags_t);
   localparam logic [CNT_W-1:0] NPX_C = CNT_W'(NPX);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      pb_tags_t      tags;
   } entry_t;

   pipe_pool_buf_state_t state;
   logic [CNT_W-1:0] rw_q, nr_q, nf_q;
   logic [CNT_W-1:0] col, row, feat;
   logic             full, empty, push, pop, in_ready, geom_ok;
   logic             last_col, last_row, last_feat, drain_done;
   logic [LW-1:0]    level;
   entry_t           wr_entry, rd_entry;

   assign geom_ok = (row_width_i != '0) && (n_rows_i != '0) && (n_feat_i != '0)
                    && ((row_width_i % NPX_C) == '0);

   assign in_ready  = (state == PB_RUN) && !full;
   assign push      = bus.y_in_TVALID_i && in_ready;
   assign pop       = bus.pool_TREADY_i && !empty;
   assign last_col  = (col == rw_q - NPX_C);
   assign last_row  = (row == nr_q - ONE);
   assign last_feat = (feat == nf_q - ONE);
   // Retire the job on the edge that empties the FIFO so done and !busy line up
   assign drain_done = (state == PB_DRAIN) && (empty || (pop && level == LW'(1)));

   assign wr_entry.data      = bus.y_in_TDATA_i;
   assign wr_entry.keep      = bus.y_in_TKEEP_i;
   assign wr_entry.tags.eol  = last_col;
   assign wr_entry.tags.last = last_col && last_row;

   pool_stream_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (clear),
      .push  (push),
      .pop   (pop),
      .wdata (wr_entry),
      .rdata (rd_entry),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= PB_IDLE;
         rw_q   <= '0;
         nr_q   <= '0;
         nf_q   <= '0;
         col    <= '0;
         row    <= '0;
         feat   <= '0;
         done_o <= 1'b0;
         err_o  <= 1'b0;
      end else if (clear) begin
         state  <= PB_IDLE;
         rw_q   <= '0;
         nr_q   <= '0;
         nf_q   <= '0;
         col    <= '0;
         row    <= '0;
         feat   <= '0;
         done_o <= 1'b0;
         err_o  <= 1'b0;
      end else begin
         done_o <= 1'b0;
         err_o  <= 1'b0;
         case (state)
            PB_IDLE: begin
               if (start_i) begin
                  if (geom_ok) begin
                     rw_q  <= row_width_i;
                     nr_q  <= n_rows_i;
                     nf_q  <= n_feat_i;
                     col   <= '0;
                     row   <= '0;
                     feat  <= '0;
                     state <= PB_RUN;
                  end else begin
                     err_o <= 1'b1;
                  end
               end
            end
            PB_RUN: begin
               if (push) begin
                  if (last_col) begin
                     col <= '0;
                     if (last_row) begin
                        row  <= '0;
                        feat <= feat + ONE;
                        if (last_feat) state <= PB_DRAIN;
                     end else begin
                        row <= row + ONE;
                     end
                  end else begin
                     col <= col + NPX_C;
                  end
               end
            end
            PB_DRAIN: begin
               if (drain_done) begin
                  done_o <= 1'b1;
                  state  <= PB_IDLE;
               end
            end
            default: state <= PB_IDLE;
         endcase
      end
   end

   assign busy_o  = (state != PB_IDLE);
   assign level_o = level;

   // Head fields are forced to zero while empty so stale entries never show
   assign bus.y_in_TREADY_o = in_ready;
   assign bus.pool_TVALID_o = !empty;
   assign bus.pool_TDATA_o  = empty ? '0 : rd_entry.data;
   assign bus.pool_TKEEP_o  = empty ? '0 : rd_entry.keep;
   assign bus.pool_TSTRB_o  = empty ? '0 : rd_entry.keep;
   assign bus.pool_EOL_o    = !empty && rd_entry.tags.eol;
   assign bus.pool_TLAST_o  = !empty && rd_entry.tags.last;

endmodule
